// File: rtl/multi_digit_ssd_mux_if.sv
// Bus bundle for multi_digit_ssd_mux.
//   master : formatting logic side; drives value/dp/lz/load, observes display pins
//   slave  : display driver side
// Signals:
//   i_value       4*par_digits  hex nibbles, digit 0 in bits [3:0]
//   i_dp          par_digits    decimal point request per digit
//   i_lz_suppress 1             leading-zero suppression enable (sampled with i_load)
//   i_load        1             one-cycle strobe capturing the three fields above
//   o_seg         7             segments {g,f,e,d,c,b,a}, active-high
//   o_dp          1             decimal point, active-high
//   o_sel         par_digits    one-hot digit select
//   o_frame_tick  1             one-cycle pulse at each frame wrap
interface multi_digit_ssd_mux_if #(
  parameter int par_digits = 4
);
  logic [4*par_digits-1:0] i_value;
  logic [par_digits-1:0]   i_dp;
  logic                    i_lz_suppress;
  logic                    i_load;
  logic [6:0]              o_seg;
  logic                    o_dp;
  logic [par_digits-1:0]   o_sel;
  logic                    o_frame_tick;

  modport master (
    output i_value, i_dp, i_lz_suppress, i_load,
    input  o_seg, o_dp, o_sel, o_frame_tick
  );

  modport slave (
    input  i_value, i_dp, i_lz_suppress, i_load,
    output o_seg, o_dp, o_sel, o_frame_tick
  );
endinterface

// File: rtl/multi_digit_ssd_mux.sv
// N-digit hex seven-segment multiplexer, single 20 MHz clock domain.
// Each digit owns a slot of par_slot_cycles; the first par_blank_cycles of a
// slot keep every select inactive to avoid ghosting. Loaded values land in a
// shadow set and are promoted to the active set only at frame wrap, so a
// displayed frame never mixes old and new data.
// Ports:
//   i_clk_20mhz  system clock
//   i_rst_20mhz  synchronous active-high reset
//   bus          multi_digit_ssd_mux_if.slave (value/dp/lz/load in, seg/dp/sel/tick out)
module multi_digit_ssd_mux #(
  parameter int par_digits         = 4,
  parameter int par_slot_cycles    = 50000,
  parameter int par_blank_cycles   = 1000,
  parameter bit par_sel_active_low = 1'b0
) (
  input logic                    i_clk_20mhz,
  input logic                    i_rst_20mhz,
  multi_digit_ssd_mux_if.slave   bus
);

  localparam int CNT_W = $clog2(par_slot_cycles);
  localparam int DIG_W = (par_digits > 1) ? $clog2(par_digits) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(par_slot_cycles - 1);
  localparam logic [DIG_W-1:0]      DIG_LAST = DIG_W'(par_digits - 1);
  localparam logic [par_digits-1:0] SEL_IDLE = {par_digits{par_sel_active_low}};

  typedef enum logic {PH_BLANK, PH_DRIVE} phase_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'h3F;
      4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;
      4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;
      4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;
      4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;
      4'h9: seg_decode = 7'h67;
      4'hA: seg_decode = 7'h77;
      4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;
      4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;
      4'hF: seg_decode = 7'h71;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  // Slot position state and data register sets
  logic [CNT_W-1:0]        cnt_p0, cnt_n;
  logic [DIG_W-1:0]        dig_p0, dig_n;
  logic                    wrap_p0, wrap_n;
  logic [4*par_digits-1:0] shd_value, act_value;
  logic [par_digits-1:0]   shd_dp, act_dp;
  logic                    shd_lz, act_lz;

  // Registered display outputs
  logic [6:0]              seg_p1, seg_n;
  logic                    dp_p1, dp_n;
  logic [par_digits-1:0]   sel_p1, sel_n;
  logic                    tick_p1;

  phase_t                  phase;
  logic [par_digits-1:0]   supp;
  logic                    lz_scan;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_supp;

  // Leading-zero mask: walk down from the top digit until a nonzero nibble
  // or a requested dp stops the scan. Digit 0 is never part of the walk.
  always_comb begin
    supp    = '0;
    lz_scan = act_lz;
    for (int k = par_digits - 1; k >= 1; k--) begin
      if (lz_scan && (act_value[4*k +: 4] == 4'h0) && !act_dp[k]) supp[k] = 1'b1;
      else lz_scan = 1'b0;
    end
  end

  // Next slot position, phase and output values
  always_comb begin
    cnt_n  = cnt_p0 + 1'b1;
    dig_n  = dig_p0;
    wrap_n = 1'b0;
    if (cnt_p0 == CNT_LAST) begin
      cnt_n = '0;
      if (dig_p0 == DIG_LAST) begin
        dig_n  = '0;
        wrap_n = 1'b1;
      end else begin
        dig_n = dig_p0 + 1'b1;
      end
    end

    phase = (int'(cnt_p0) < par_blank_cycles) ? PH_BLANK : PH_DRIVE;

    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_supp = 1'b0;
    sel_n    = '0;
    for (int k = 0; k < par_digits; k++) begin
      if (dig_p0 == DIG_W'(k)) begin
        cur_nib  = act_value[4*k +: 4];
        cur_dp   = act_dp[k];
        cur_supp = supp[k];
        sel_n[k] = (phase == PH_DRIVE);
      end
    end
    sel_n = sel_n ^ SEL_IDLE;

    // Suppressed digits keep their select so every digit has the same duty.
    seg_n = 7'h00;
    dp_n  = 1'b0;
    if (phase == PH_DRIVE && !cur_supp) begin
      seg_n = seg_decode(cur_nib);
      dp_n  = cur_dp;
    end
  end

  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      cnt_p0    <= '0;
      dig_p0    <= '0;
      wrap_p0   <= 1'b0;
      shd_value <= '0;
      shd_dp    <= '0;
      shd_lz    <= 1'b0;
      act_value <= '0;
      act_dp    <= '0;
      act_lz    <= 1'b0;
      seg_p1    <= 7'h00;
      dp_p1     <= 1'b0;
      sel_p1    <= SEL_IDLE;
      tick_p1   <= 1'b0;
    end else begin
      cnt_p0  <= cnt_n;
      dig_p0  <= dig_n;
      wrap_p0 <= wrap_n;
      if (bus.i_load) begin
        shd_value <= bus.i_value;
        shd_dp    <= bus.i_dp;
        shd_lz    <= bus.i_lz_suppress;
      end
      // Nonblocking read of the shadow: a load on the wrap edge waits a frame.
      if (wrap_n) begin
        act_value <= shd_value;
        act_dp    <= shd_dp;
        act_lz    <= shd_lz;
      end
      seg_p1  <= seg_n;
      dp_p1   <= dp_n;
      sel_p1  <= sel_n;
      // Delayed one edge so the pulse lines up with digit 0's first blank cycle.
      tick_p1 <= wrap_p0;
    end
  end

  assign bus.o_seg        = seg_p1;
  assign bus.o_dp         = dp_p1;
  assign bus.o_sel        = sel_p1;
  assign bus.o_frame_tick = tick_p1;

endmodule

// File: tb/tb_multi_digit_ssd_mux.sv
module tb_multi_digit_ssd_mux;

  localparam int S  = 20;
  localparam int B  = 4;
  localparam int NS = 4 * S;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_digit_ssd_mux_if #(.par_digits(4)) bus1 ();
  multi_digit_ssd_mux_if #(.par_digits(8)) bus2 ();
  multi_digit_ssd_mux_if #(.par_digits(1)) bus3 ();

  multi_digit_ssd_mux #(.par_digits(4), .par_slot_cycles(S), .par_blank_cycles(B),
                        .par_sel_active_low(1'b0))
    dut1 (.i_clk_20mhz(clk), .i_rst_20mhz(rst), .bus(bus1));
  multi_digit_ssd_mux #(.par_digits(8), .par_slot_cycles(4), .par_blank_cycles(1),
                        .par_sel_active_low(1'b1))
    dut2 (.i_clk_20mhz(clk), .i_rst_20mhz(rst), .bus(bus2));
  multi_digit_ssd_mux #(.par_digits(1), .par_slot_cycles(3), .par_blank_cycles(1),
                        .par_sel_active_low(1'b0))
    dut3 (.i_clk_20mhz(clk), .i_rst_20mhz(rst), .bus(bus3));

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][6:0] seg;   // expected pattern per digit, index = digit
    logic [3:0]      edp;   // expected dp per digit
  } vec_t;

  typedef struct {
    int          p;
    logic [12:0] bits;      // {seg, dp, sel, tick}
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[10];
  vec_t vz, v1111, v2222, v8888;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Expected output for frame positions [a,b); position 0 is digit 0's first blank cycle.
  task automatic push_frame(input vec_t v, input int a, input int b, input bit tick0);
    exp_t e;
    logic [3:0] sel;
    for (int p = a; p < b; p++) begin
      int d, c;
      d = p / S;
      c = p % S;
      e.p = p;
      if (c < B) begin
        e.bits = {7'h00, 1'b0, 4'h0, (p == 0) && tick0};
      end else begin
        sel = 4'b0001 << d;
        e.bits = {v.seg[d], v.edp[d], sel, 1'b0};
      end
      q.push_back(e);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("frame p=%0d {seg,dp,sel,tick}", e.p),
          {19'd0, bus1.o_seg, bus1.o_dp, bus1.o_sel, bus1.o_frame_tick}, {19'd0, e.bits});
      @(negedge clk);
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus1.o_frame_tick && n < 200);
    if (!bus1.o_frame_tick) begin
      total++;
      bad++;
      $display("FAIL frame_tick timeout: got no tick within %0d cycles", n);
    end
  endtask

  // Called at a negedge; returns at the negedge after the loading edge.
  task automatic load(input logic [15:0] val, input logic [3:0] dp, input logic lz);
    bus1.i_value       = val;
    bus1.i_dp          = dp;
    bus1.i_lz_suppress = lz;
    bus1.i_load        = 1'b1;
    @(posedge clk);
    #1 bus1.i_load = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{16'h1A3F, 4'b0000, 1'b0, {7'h06, 7'h77, 7'h4F, 7'h71}, 4'b0000};
    vecs[1] = '{16'h0040, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h66, 7'h3F}, 4'b0000};
    vecs[2] = '{16'h0005, 4'b0010, 1'b1, {7'h00, 7'h00, 7'h3F, 7'h6D}, 4'b0010};
    vecs[3] = '{16'h0000, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000};
    vecs[4] = '{16'h0000, 4'b0100, 1'b1, {7'h00, 7'h3F, 7'h3F, 7'h3F}, 4'b0100};
    vecs[5] = '{16'hF0F0, 4'b1000, 1'b1, {7'h71, 7'h3F, 7'h71, 7'h3F}, 4'b1000};
    vecs[6] = '{16'h89AB, 4'b0000, 1'b0, {7'h7F, 7'h67, 7'h77, 7'h7C}, 4'b0000};
    vecs[7] = '{16'hCDE7, 4'b1111, 1'b0, {7'h39, 7'h5E, 7'h79, 7'h07}, 4'b1111};
    vecs[8] = '{16'h0000, 4'b0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000};
    vecs[9] = '{16'h0100, 4'b0001, 1'b1, {7'h00, 7'h06, 7'h3F, 7'h3F}, 4'b0001};
    vz      = '{16'h0000, 4'b0000, 1'b0, {4{7'h3F}}, 4'b0000};
    v1111   = '{16'h1111, 4'b0000, 1'b0, {4{7'h06}}, 4'b0000};
    v2222   = '{16'h2222, 4'b0000, 1'b0, {4{7'h5B}}, 4'b0000};
    v8888   = '{16'h8888, 4'b0000, 1'b0, {4{7'h7F}}, 4'b0000};

    bus1.i_value = '0; bus1.i_dp = '0; bus1.i_lz_suppress = 1'b0; bus1.i_load = 1'b0;
    bus2.i_value = '0; bus2.i_dp = '0; bus2.i_lz_suppress = 1'b0; bus2.i_load = 1'b0;
    bus3.i_value = '0; bus3.i_dp = '0; bus3.i_lz_suppress = 1'b0; bus3.i_load = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset {seg,dp,sel,tick}",
        {19'd0, bus1.o_seg, bus1.o_dp, bus1.o_sel, bus1.o_frame_tick}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    // First frame after reset: zero data, no tick on its first cycle
    push_frame(vz, 0, NS, 1'b0);
    drain();

    // Table of loaded values; each load lands just after a frame start
    for (int i = 0; i < 10; i++) begin
      load(vecs[i].value, vecs[i].dp, vecs[i].lz);
      push_frame(vecs[i], 0, NS, 1'b1);
      wait_tick();
      drain();
    end

    // Mid-frame reload: rest of the frame stays old, next frame is new
    load(16'h1111, 4'b0000, 1'b0);
    wait_tick();
    push_frame(v1111, 0, 30, 1'b1);
    drain();
    load(16'h2222, 4'b0000, 1'b0);
    push_frame(v1111, 31, NS, 1'b1);
    push_frame(v2222, 0, NS, 1'b1);
    drain();

    // Load on the tick-generating edge: one more frame of old data
    push_frame(v2222, 0, NS - 1, 1'b1);
    drain();
    load(16'h8888, 4'b0000, 1'b0);
    push_frame(v2222, 0, NS, 1'b1);
    push_frame(v8888, 0, NS, 1'b1);
    drain();

    // Reset during digit 2 drive with a pending shadow load
    push_frame(v8888, 0, 48, 1'b1);
    drain();
    load(16'h9999, 4'b0000, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("mid-slot reset {seg,dp,sel,tick}",
           {19'd0, bus1.o_seg, bus1.o_dp, bus1.o_sel, bus1.o_frame_tick}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_frame(vz, 0, NS, 1'b0);
    push_frame(vz, 0, NS, 1'b1);
    drain();

    // Active-low 8-digit and single-digit instances from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    chk("8dig reset sel", {24'd0, bus2.o_sel}, 32'hFF);
    chk("1dig reset sel", {31'd0, bus3.o_sel}, 32'd0);
    rst = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      int m, d, c;
      logic [7:0] esel;
      logic [6:0] eseg;
      @(negedge clk);
      m = n - 1;
      d = (m % 32) / 4;
      c = m % 4;
      esel = (c < 1) ? 8'hFF : ~(8'h01 << d);
      eseg = (c < 1) ? 7'h00 : 7'h3F;
      chk($sformatf("8dig n=%0d {sel,seg,tick}", n),
          {16'd0, bus2.o_sel, bus2.o_seg, bus2.o_frame_tick},
          {16'd0, esel, eseg, (m > 0) && (m % 32 == 0)});
      c = m % 3;
      chk($sformatf("1dig n=%0d {sel,seg,tick}", n),
          {23'd0, bus3.o_sel, bus3.o_seg, bus3.o_frame_tick},
          {23'd0, c >= 1, (c >= 1) ? 7'h3F : 7'h00, (m > 0) && (c == 0)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_digit_ssd_mux.md
# multi_digit_ssd_mux

Parametrised N-digit hexadecimal seven-segment display driver running entirely in the 20 MHz domain, with no generated clock. It decodes `par_digits` hex nibbles into segment patterns and time-multiplexes them onto one shared segment bus with a one-hot digit select. It adds per-digit decimal points, leading-zero suppression, an anti-ghosting blank interval, and tear-free frame-synchronous value updates. It sits between the accelerometer readout formatting logic and the board/Pmod segment pins, generalising the two-digit PmodSSD driver to 1–8 digits.

## Interface
- `par_digits`, default 4: number of digits; legal range 1..8.
- `par_slot_cycles`, default 50000: clock cycles per digit slot. At 20 MHz and 4 digits this gives 400 Hz per slot and 100 Hz per frame. Minimum 2.
- `par_blank_cycles`, default 1000: cycles at the start of each slot with all selects inactive. Must be less than `par_slot_cycles`; 0 disables blanking.
- `par_sel_active_low`, default 0: 1 inverts `o_sel` polarity.

Ports:
- `i_clk_20mhz`  in  1  system clock; the only clock.
- `i_rst_20mhz`  in  1  reset, synchronous, active-high.
- `i_value`  in  4*par_digits  hex nibbles; digit k = `i_value[4k+3:4k]`, digit 0 rightmost.
- `i_dp`  in  par_digits  decimal point request per digit.
- `i_lz_suppress`  in  1  enables leading-zero suppression; sampled with `i_load`.
- `i_load`  in  1  one-cycle strobe; captures `i_value`, `i_dp`, `i_lz_suppress` into the shadow register.
- `o_seg`  out  7  segments {g,f,e,d,c,b,a}, active-high.
- `o_dp`  out  1  decimal point, active-high.
- `o_sel`  out  par_digits  one-hot digit select; all inactive during blank.
- `o_frame_tick`  out  1  one-cycle pulse at each frame wrap.

## Operation
- Decode, 0..F in hex: 3F 06 5B 4F 66 6D 7D 07 7F 67 77 7C 39 5E 79 71.
- Shadow and active register sets:
  - `i_load` writes the shadow set.
  - At each frame wrap, the shadow set is copied to the active set.
  - Only the active set drives the display, so a frame never mixes old and new values.
- Slot counter `cnt`, range 0..par_slot_cycles-1, and digit index `dig`, range 0..par_digits-1.
  - `cnt` wraps to 0 and `dig` increments.
  - When `dig` wraps from par_digits-1 to 0, this is a frame wrap: active set updates and `o_frame_tick` pulses.
- Slot phases, one FSM encoded by `cnt`:
  - BLANK when `cnt` < par_blank_cycles: `o_sel` inactive, `o_seg`=0, `o_dp`=0.
  - DRIVE otherwise: `o_sel[dig]` active, `o_seg`=decode(active nibble[dig]), `o_dp`=active dp[dig].
- Leading-zero suppression, when active `lz` is set:
  - Scan from digit par_digits-1 downward.
  - A digit is suppressed while its nibble is 0 and its dp is 0.
  - The scan stops at the first nonzero nibble or the first set dp.
  - Digit 0 is never suppressed.
  - A suppressed digit in DRIVE: select still asserted, `o_seg`=0, `o_dp`=0. This keeps the duty cycle uniform.
- `i_load` on the same cycle as a frame wrap:
  - The copy uses the pre-load shadow.
  - The new data appears from the following frame.
- Multiple `i_load` within one frame: the last one wins.

## Timing
- All outputs are registered. Output latency is 1 cycle from the `cnt`/`dig` state.
- Reset values:
  - `o_seg`=0, `o_dp`=0, `o_sel` inactive (all 0, or all 1 when `par_sel_active_low`=1), `o_frame_tick`=0.
  - `cnt`=0, `dig`=0.
  - Shadow and active sets all 0, `lz`=0.
- After reset deassertion, digit k is driven on output cycles k*S+B+1 through (k+1)*S, counted from the first non-reset edge, where S = par_slot_cycles and B = par_blank_cycles.
- `o_frame_tick` is high for exactly one cycle every par_digits*S cycles. It coincides with the first output cycle of digit 0's BLANK phase.
- Reset asserted mid-slot forces reset values on the next edge. Any pending shadow data is discarded.
- `par_digits`=1: every slot end is a frame wrap and `o_sel` is a 1-bit toggle between select and blank.

## Test plan
- Params 4/20/4/0. Reset, load `i_value`=16'h1A3F with dp=0 and lz=0, wait 2 frames.
  - Expect digit 0 = 71, 1 = 4F, 2 = 77, 3 = 06, in that order.
  - Each digit selected for 16 cycles after 4 blank cycles.
  - `o_frame_tick` period 80.
- Load 16'h0040 with lz=1 and dp=0.
  - Expect digits 3 and 2 selected with `o_seg`=0, digit 1 = 66, digit 0 = 3F.
  - Then load 16'h0005 with dp=4'b0010: digit 1 shows 3F with `o_dp`=1, digit 0 shows 6D, digits 3 and 2 blank.
- Load 16'h1111, then pulse `i_load` with 16'h2222 mid-frame.
  - Expect the rest of that frame all 06.
  - Expect the next frame all 5B, with no mixed frame.
- Pulse `i_load` with 16'h8888 exactly on the `o_frame_tick`-generating edge.
  - Expect the following frame to show old data.
  - Expect the frame after to show 7F.
- Assert reset during the DRIVE phase of digit 2.
  - Expect all outputs at reset values on the next cycle.
  - After release, expect the sequence to restart at digit 0 blank with all-zero data displayed as 3F.
- `par_sel_active_low`=1 with `par_digits`=8: expect `o_sel` idle at 8'hFF and a single 0 walking from bit 0 to bit 7.
